// File: rtl/ddr3_ctrl_pkg.sv
// Shared DDR3 controller definitions.
// Holds the Avalon width constants and the arbiter owner-state encoding
// used by the interface, the arbiter and its burst tracker.
package ddr3_ctrl_pkg;

    localparam int ADDR_W = 26;   // Avalon word-address width
    localparam int DATA_W = 128;  // Avalon data width
    localparam int SIZE_W = 3;    // Avalon burst-size width

    // Owner of the DDR3 Avalon port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_OWN = 2'd1,
        WR_OWN = 2'd2
    } owner_e;

endpackage

// File: rtl/ddr3_avl_arbiter_if.sv
// Bundle of every handshake and bus signal around the DDR3 arbiter:
// read requester, write requester and the DDR3 Avalon controller port.
//   slave  : view of the arbiter (requests in, controller commands out)
//   master : view of the environment driving the arbiter
interface ddr3_avl_arbiter_if #(
    parameter int ADDR_W = ddr3_ctrl_pkg::ADDR_W
);
    import ddr3_ctrl_pkg::*;

    // Read requester
    logic                rd_read_req;
    logic                rd_burstbegin;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SIZE_W-1:0]   rd_size;
    logic                rd_ready;
    logic                rd_data_valid;
    logic [DATA_W-1:0]   rd_data;

    // Write requester
    logic                wr_write_req;
    logic                wr_burstbegin;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SIZE_W-1:0]   wr_size;
    logic [DATA_W-1:0]   wr_wdata;
    logic                wr_ready;

    // DDR3 controller Avalon port
    logic                ddr3_avl_ready;
    logic                ddr3_avl_read_data_valid;
    logic [DATA_W-1:0]   ddr3_avl_read_data;
    logic                ddr3_avl_burstbegin;
    logic                ddr3_avl_read_req;
    logic                ddr3_avl_write_req;
    logic [ADDR_W-1:0]   ddr3_avl_addr;
    logic [SIZE_W-1:0]   ddr3_avl_size;
    logic [DATA_W-1:0]   ddr3_avl_wdata;

    modport slave (
        input  rd_read_req, rd_burstbegin, rd_addr, rd_size,
        input  wr_write_req, wr_burstbegin, wr_addr, wr_size, wr_wdata,
        input  ddr3_avl_ready, ddr3_avl_read_data_valid, ddr3_avl_read_data,
        output rd_ready, rd_data_valid, rd_data, wr_ready,
        output ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_write_req,
        output ddr3_avl_addr, ddr3_avl_size, ddr3_avl_wdata
    );

    modport master (
        output rd_read_req, rd_burstbegin, rd_addr, rd_size,
        output wr_write_req, wr_burstbegin, wr_addr, wr_size, wr_wdata,
        output ddr3_avl_ready, ddr3_avl_read_data_valid, ddr3_avl_read_data,
        input  rd_ready, rd_data_valid, rd_data, wr_ready,
        input  ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_write_req,
        input  ddr3_avl_addr, ddr3_avl_size, ddr3_avl_wdata
    );

endinterface

// File: rtl/ddr3_burst_counter.sv
// Write-burst beat tracker.
// Latches the burst length on the first beat (size 0 counts as 1) and
// counts beats modulo that length; flags the completing beat.
//   ddr3_clk, ddr3_reset : clock, synchronous active-high reset
//   clear_i              : abandon any partial burst (owner leaves WR)
//   beat_i               : a write beat is accepted this cycle
//   size_i               : wr_size presented with the beat
//   beat_cnt_o           : beats already taken in the current burst
//   done_o               : this beat completes the burst
module ddr3_burst_counter
    import ddr3_ctrl_pkg::*;
(
    input  logic              ddr3_clk,
    input  logic              ddr3_reset,
    input  logic              clear_i,
    input  logic              beat_i,
    input  logic [SIZE_W-1:0] size_i,
    output logic [2:0]        beat_cnt_o,
    output logic              done_o
);

    logic [2:0] beat_cnt_q, beat_cnt_d;
    logic [2:0] burst_len_q, burst_len_d;
    logic [2:0] size_norm;
    logic [2:0] cur_len;

    assign size_norm  = (size_i == 3'd0) ? 3'd1 : size_i;
    // The first beat uses the live size since burst_len_q is not loaded yet
    assign cur_len    = (beat_cnt_q == 3'd0) ? size_norm : burst_len_q;
    assign done_o     = beat_i && ((beat_cnt_q + 3'd1) == cur_len);
    assign beat_cnt_o = beat_cnt_q;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        burst_len_d = burst_len_q;
        if (clear_i) begin
            beat_cnt_d = 3'd0;
        end else if (beat_i) begin
            if (beat_cnt_q == 3'd0) begin
                burst_len_d = size_norm;
            end
            beat_cnt_d = done_o ? 3'd0 : beat_cnt_q + 3'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge ddr3_clk) begin
        if (ddr3_reset) begin
            beat_cnt_q  <= 3'd0;
            burst_len_q <= 3'd1;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            burst_len_q <= burst_len_d;
        end
    end

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Two-requester arbiter in front of a DDR3 Avalon controller port.
// A registered owner FSM (IDLE / RD_OWN / WR_OWN) grants the port to the
// read or write requester, round-robin on ties, with at most MAX_RUN
// commands/bursts per turn while the other side waits. Write bursts are
// never split. Read data is passed straight through.
//   ddr3_clk, ddr3_reset : clock, synchronous active-high reset
//   bus (slave)          : read/write requester ports and DDR3 Avalon port
module ddr3_avl_arbiter #(
    parameter int MAX_RUN = 16,
    parameter int ADDR_W  = ddr3_ctrl_pkg::ADDR_W
) (
    input  logic              ddr3_clk,
    input  logic              ddr3_reset,
    ddr3_avl_arbiter_if.slave bus
);
    import ddr3_ctrl_pkg::*;

    localparam int                RUN_W   = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_RUN);

    owner_e            state_q, state_d;
    owner_e            last_owner_q, last_owner_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d, run_inc;
    logic [2:0]        beat_cnt;
    logic              wr_beat, burst_done, to_idle;
    logic [ADDR_W-1:0] addr_mux;

    assign wr_beat = (state_q == WR_OWN) && bus.wr_write_req && bus.ddr3_avl_ready;
    assign run_inc = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + 1'b1;

    ddr3_burst_counter u_burst_counter (
        .ddr3_clk   (ddr3_clk),
        .ddr3_reset (ddr3_reset),
        .clear_i    (to_idle),
        .beat_i     (wr_beat),
        .size_i     (bus.wr_size),
        .beat_cnt_o (beat_cnt),
        .done_o     (burst_done)
    );

    // Next-state logic; a stalled controller freezes everything.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        run_cnt_d    = run_cnt_q;
        to_idle      = 1'b0;
        if (bus.ddr3_avl_ready) begin
            case (state_q)
                IDLE: begin
                    if (bus.rd_read_req && bus.wr_write_req)
                        state_d = (last_owner_q == RD_OWN) ? WR_OWN : RD_OWN;
                    else if (bus.rd_read_req)
                        state_d = RD_OWN;
                    else if (bus.wr_write_req)
                        state_d = WR_OWN;
                end
                RD_OWN: begin
                    if (!bus.rd_read_req) begin
                        to_idle = 1'b1;
                    end else begin
                        run_cnt_d = run_inc;
                        if (run_inc == RUN_MAX && bus.wr_write_req)
                            to_idle = 1'b1;
                    end
                end
                WR_OWN: begin
                    // Leave only on a burst boundary: hand over to a waiting
                    // reader once the run budget is used, or when writes stop.
                    if (burst_done) begin
                        run_cnt_d = run_inc;
                        if (run_inc == RUN_MAX && bus.rd_read_req)
                            to_idle = 1'b1;
                    end else if (!bus.wr_write_req && beat_cnt == 3'd0) begin
                        to_idle = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (to_idle) begin
                state_d      = IDLE;
                last_owner_d = state_q;
                run_cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge ddr3_clk) begin
        if (ddr3_reset) begin
            state_q      <= IDLE;
            last_owner_q <= WR_OWN;  // read side wins the first tie
            run_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

    // Command mux: the owner's request is forwarded unregistered.
    always_comb begin
        bus.ddr3_avl_burstbegin = 1'b0;
        bus.ddr3_avl_read_req   = 1'b0;
        bus.ddr3_avl_write_req  = 1'b0;
        addr_mux                = '0;
        bus.ddr3_avl_size       = '0;
        bus.ddr3_avl_wdata      = '0;
        bus.rd_ready            = 1'b0;
        bus.wr_ready            = 1'b0;
        case (state_q)
            RD_OWN: begin
                bus.ddr3_avl_burstbegin = bus.rd_burstbegin;
                bus.ddr3_avl_read_req   = bus.rd_read_req;
                addr_mux                = bus.rd_addr;
                bus.ddr3_avl_size       = bus.rd_size;
                bus.rd_ready            = bus.ddr3_avl_ready;
            end
            WR_OWN: begin
                bus.ddr3_avl_burstbegin = bus.wr_burstbegin;
                bus.ddr3_avl_write_req  = bus.wr_write_req;
                addr_mux                = bus.wr_addr;
                bus.ddr3_avl_size       = bus.wr_size;
                bus.ddr3_avl_wdata      = bus.wr_wdata;
                bus.wr_ready            = bus.ddr3_avl_ready;
            end
            default: ;
        endcase
    end

    assign bus.ddr3_avl_addr = addr_mux;
    assign bus.rd_data_valid = bus.ddr3_avl_read_data_valid;
    assign bus.rd_data       = bus.ddr3_avl_read_data;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed self-checking bench for ddr3_avl_arbiter (MAX_RUN=16).
module tb_ddr3_avl_arbiter;
  import ddr3_ctrl_pkg::*;

  logic ddr3_clk = 1'b0;
  logic ddr3_reset;
  int   tests = 0;
  int   fails = 0;

  always #5 ddr3_clk = ~ddr3_clk;

  ddr3_avl_arbiter_if #(.ADDR_W(26)) bus ();

  ddr3_avl_arbiter #(.MAX_RUN(16), .ADDR_W(26)) dut (
    .ddr3_clk   (ddr3_clk),
    .ddr3_reset (ddr3_reset),
    .bus        (bus)
  );

  // {ddr3_avl_read_req, ddr3_avl_write_req, rd_ready, wr_ready}
  function automatic logic [3:0] ctl();
    return {bus.ddr3_avl_read_req, bus.ddr3_avl_write_req, bus.rd_ready, bus.wr_ready};
  endfunction

  // {read accepted, write beat accepted}
  function automatic logic [1:0] acc();
    return {bus.ddr3_avl_read_req & bus.rd_ready, bus.ddr3_avl_write_req & bus.wr_ready};
  endfunction

  task automatic check(input bit ok, input string msg);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic tick();
    @(posedge ddr3_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    bus.rd_read_req              = 1'b0;
    bus.rd_burstbegin            = 1'b0;
    bus.rd_addr                  = '0;
    bus.rd_size                  = '0;
    bus.wr_write_req             = 1'b0;
    bus.wr_burstbegin            = 1'b0;
    bus.wr_addr                  = '0;
    bus.wr_size                  = '0;
    bus.wr_wdata                 = '0;
    bus.ddr3_avl_ready           = 1'b1;
    bus.ddr3_avl_read_data_valid = 1'b0;
    bus.ddr3_avl_read_data       = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    ddr3_reset = 1'b1;
    tick();
    tick();
    ddr3_reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    ddr3_reset                   = 1'b1;
    bus.rd_read_req              = 1'b1;
    bus.rd_addr                  = 26'h3ffffff;
    bus.rd_size                  = 3'd7;
    bus.wr_write_req             = 1'b1;
    bus.wr_wdata                 = {4{32'hA5A5_5A5A}};
    bus.ddr3_avl_read_data_valid = 1'b1;
    bus.ddr3_avl_read_data       = {4{32'hDEAD_BEEF}};
    tick();
    tick();
    settle();
    check({bus.ddr3_avl_burstbegin, ctl()} === 5'b0,
          $sformatf("reset_ctl: got %b expected 00000", {bus.ddr3_avl_burstbegin, ctl()}));
    check({bus.ddr3_avl_addr, bus.ddr3_avl_size, bus.ddr3_avl_wdata} === '0,
          $sformatf("reset_bus: got addr %h size %h wdata %h expected all 0",
                    bus.ddr3_avl_addr, bus.ddr3_avl_size, bus.ddr3_avl_wdata));
    check(bus.rd_data_valid === 1'b1 && bus.rd_data === {4{32'hDEAD_BEEF}},
          $sformatf("reset_passthru: got %b %h expected 1 %h",
                    bus.rd_data_valid, bus.rd_data, {4{32'hDEAD_BEEF}}));
    check(dut.beat_cnt === 3'd0 && dut.run_cnt_q === '0,
          $sformatf("reset_counters: got beat %0d run %0d expected 0 0", dut.beat_cnt, dut.run_cnt_q));
    do_reset();
  endtask

  task automatic test_read_only();
    logic [25:0] exp_addr [3] = '{26'h0001000, 26'h0001004, 26'h0001008};
    logic [3:0]  exp;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.rd_read_req   = (c <= 3);
      bus.rd_burstbegin = (c <= 3);
      bus.rd_size       = 3'd1;
      bus.rd_addr       = (c == 0) ? exp_addr[0] : exp_addr[(c - 1) % 3];
      settle();
      exp = {(c >= 1 && c <= 3), 1'b0, (c >= 1 && c <= 4), 1'b0};
      check(ctl() === exp, $sformatf("read_only_ctl c%0d: got %b expected %b", c, ctl(), exp));
      if (c >= 1 && c <= 3)
        check(bus.ddr3_avl_addr === exp_addr[c-1],
              $sformatf("read_only_addr c%0d: got %h expected %h", c, bus.ddr3_avl_addr, exp_addr[c-1]));
    end
  endtask

  task automatic test_tie();
    logic [1:0] req_t [11] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01,
                               2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
    logic [3:0] exp_t [11] = '{4'b0000, 4'b1010, 4'b1010, 4'b0010, 4'b0000, 4'b0101,
                               4'b0001, 4'b0000, 4'b1010, 4'b0010, 4'b0000};
    do_reset();
    for (int c = 0; c < 11; c++) begin
      tick();
      bus.rd_read_req  = req_t[c][1];
      bus.wr_write_req = req_t[c][0];
      bus.wr_size      = 3'd1;
      settle();
      check(ctl() === exp_t[c], $sformatf("tie_rr c%0d: got %b expected %b", c, ctl(), exp_t[c]));
    end
  endtask

  task automatic test_write_burst();
    // columns: {wr_write_req, rd_read_req, ddr3_avl_ready, wr_burstbegin}
    logic [3:0]   in_t  [10] = '{4'b1011, 4'b1111, 4'b1110, 4'b1100, 4'b1110,
                                 4'b1110, 4'b0110, 4'b0110, 4'b0110, 4'b0010};
    logic [3:0]   exp_t [10] = '{4'b0000, 4'b0101, 4'b0101, 4'b0100, 4'b0101,
                                 4'b0101, 4'b0001, 4'b0000, 4'b1010, 4'b0010};
    logic [127:0] wd_t  [10] = '{128'h0, 128'h0, 128'h1, 128'h2, 128'h2,
                                 128'h3, 128'h0, 128'h0, 128'h0, 128'h0};
    int beats = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      bus.wr_write_req   = in_t[c][3];
      bus.rd_read_req    = in_t[c][2];
      bus.ddr3_avl_ready = in_t[c][1];
      bus.wr_burstbegin  = in_t[c][0];
      bus.wr_size        = 3'd4;
      bus.wr_addr        = 26'h0000200;
      bus.wr_wdata       = {4{32'h1111_0000}} + wd_t[c];
      settle();
      check(ctl() === exp_t[c], $sformatf("write_burst_ctl c%0d: got %b expected %b", c, ctl(), exp_t[c]));
      if (acc()[0]) begin
        beats++;
        check(bus.ddr3_avl_wdata === {4{32'h1111_0000}} + wd_t[c],
              $sformatf("write_burst_wdata c%0d: got %h expected %h",
                        c, bus.ddr3_avl_wdata, {4{32'h1111_0000}} + wd_t[c]));
      end
    end
    check(beats == 4, $sformatf("write_burst_beats: got %0d expected 4", beats));
  endtask

  task automatic test_fairness();
    logic [1:0] exp;
    int         p;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      tick();
      bus.rd_read_req  = 1'b1;
      bus.wr_write_req = 1'b1;
      bus.wr_size      = 3'd1;
      settle();
      p   = c % 34;
      exp = (p >= 1 && p <= 16) ? 2'b10 : (p >= 18) ? 2'b01 : 2'b00;
      check(acc() === exp, $sformatf("fairness c%0d: got %b expected %b", c, acc(), exp));
    end
  endtask

  task automatic test_size_zero();
    logic [1:0] exp;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      tick();
      bus.wr_write_req = 1'b1;
      bus.rd_read_req  = (c >= 1);
      bus.wr_size      = 3'd0;
      settle();
      exp = (c >= 1 && c <= 16) ? 2'b01 : (c == 18) ? 2'b10 : 2'b00;
      check(acc() === exp, $sformatf("size_zero c%0d: got %b expected %b", c, acc(), exp));
      if (c == 1)
        check(bus.ddr3_avl_size === 3'd0,
              $sformatf("size_zero_size: got %0d expected 0", bus.ddr3_avl_size));
    end
  endtask

  task automatic test_reset_mid_burst();
    // columns: {write_req out, wr_ready}
    logic [1:0] exp_t [12] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00,
                               2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      ddr3_reset       = (c == 3);
      bus.wr_write_req = !(c == 4 || c >= 10);
      bus.wr_size      = 3'd4;
      bus.wr_wdata     = 128'(c);
      settle();
      check({bus.ddr3_avl_write_req, bus.wr_ready} === exp_t[c],
            $sformatf("reset_mid_burst c%0d: got %b expected %b",
                      c, {bus.ddr3_avl_write_req, bus.wr_ready}, exp_t[c]));
      if (c == 4)
        check({bus.ddr3_avl_burstbegin, ctl(), bus.ddr3_avl_wdata} === '0 && dut.beat_cnt === 3'd0,
              $sformatf("reset_mid_burst_idle: got ctl %b beat %0d expected 0000 0",
                        ctl(), dut.beat_cnt));
    end
  endtask

  initial begin
    ddr3_reset = 1'b1;
    drive_idle();
    test_reset();
    test_read_only();
    test_tie();
    test_write_burst();
    test_fairness();
    test_size_zero();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
